// File: rtl/neurosync_serial_pkg.sv
`default_nettype none
// ============================================================================
// neurosync_serial_pkg : state codes and 7E2 frame constants for the NeuroSync link
// Revision: 1.0
// ============================================================================
package neurosync_serial_pkg;

  localparam int c_bit_div     = 434;   // 50 MHz / 115200
  localparam int c_data_bits   = 7;
  localparam int c_stop_bits   = 2;
  localparam bit c_even_parity = 1'b1;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    INICIO   = 3'd1,
    DADOS    = 3'd2,
    PARIDADE = 3'd3,
    PARADA   = 3'd4,
    ENTREGA  = 3'd5
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/neurosync_serial_rx_if.sv
`default_nettype none
// ============================================================================
// neurosync_serial_rx_if : serial line and holding-register handshake bundle
// Revision: 1.0
// ============================================================================
interface neurosync_serial_rx_if #(
  parameter int DATA_BITS = 7
) ();
  logic                 rx;
  logic                 limpa;
  logic [DATA_BITS-1:0] dado;
  logic                 pronto;
  logic                 tem_dado;
  logic                 erro_paridade;
  logic                 erro_frame;
  logic                 overrun;
  logic [2:0]           db_estado;

  // master drives the line and consumes characters; slave is the receiver
  modport master (
    output rx, limpa,
    input  dado, pronto, tem_dado, erro_paridade, erro_frame, overrun, db_estado
  );

  modport slave (
    input  rx, limpa,
    output dado, pronto, tem_dado, erro_paridade, erro_frame, overrun, db_estado
  );
endinterface
`default_nettype wire

// File: rtl/neurosync_baud_counter.sv
`default_nettype none
// ============================================================================
// neurosync_baud_counter : free-running bit timer with clear, half/full ticks
// Revision: 1.0
// ============================================================================
module neurosync_baud_counter #(
  parameter int BIT_DIV = 434
) (
  input  wire logic clock,
  input  wire logic reset,
  input  wire logic clr,
  output logic      half,
  output logic      full
);
  localparam int CW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

  logic [CW-1:0] tick_cnt_q, tick_cnt_d;

  assign half = (tick_cnt_q == CW'(BIT_DIV/2 - 1));
  assign full = (tick_cnt_q == CW'(BIT_DIV - 1));

  always_comb begin
    tick_cnt_d = tick_cnt_q + CW'(1);
    if (clr || full) tick_cnt_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) tick_cnt_q <= '0;
    else       tick_cnt_q <= tick_cnt_d;
  end
endmodule
`default_nettype wire

// File: rtl/neurosync_serial_rx.sv
`default_nettype none
// ============================================================================
// neurosync_serial_rx : UART receiver (start, data LSB-first, even parity, stops)
// Revision: 1.0
// ============================================================================
module neurosync_serial_rx
  import neurosync_serial_pkg::*;
#(
  parameter int BIT_DIV   = c_bit_div,
  parameter int DATA_BITS = c_data_bits,
  parameter int STOP_BITS = c_stop_bits
) (
  input  wire logic            clock,
  input  wire logic            reset,
  neurosync_serial_rx_if.slave bus
);
  rx_state_t            state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic                 fr_err_q, fr_err_d;
  logic [DATA_BITS-1:0] dado_q, dado_d;
  logic                 erro_par_q, erro_par_d;
  logic                 erro_fr_q, erro_fr_d;
  logic                 pronto_q, pronto_d;
  logic                 tem_dado_q, tem_dado_d;
  logic                 overrun_q, overrun_d;

  logic w_rx_s;
  logic w_cnt_clr;
  logic w_half;
  logic w_full;

  assign w_rx_s = sync_q[1];

  neurosync_baud_counter #(.BIT_DIV(BIT_DIV)) u_baud (
    .clock (clock),
    .reset (reset),
    .clr   (w_cnt_clr),
    .half  (w_half),
    .full  (w_full)
  );

  always_comb begin
    state_d    = state_q;
    sync_d     = {sync_q[0], bus.rx};
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    fr_err_d   = fr_err_q;
    dado_d     = dado_q;
    erro_par_d = erro_par_q;
    erro_fr_d  = erro_fr_q;
    pronto_d   = 1'b0;
    tem_dado_d = tem_dado_q;
    overrun_d  = overrun_q;
    w_cnt_clr  = 1'b0;

    if (bus.limpa) begin
      tem_dado_d = 1'b0;
      overrun_d  = 1'b0;
    end

    case (state_q)
      OCIOSO: begin
        if (!w_rx_s) begin
          state_d   = INICIO;
          w_cnt_clr = 1'b1;
          bit_idx_d = 4'd0;
        end
      end
      INICIO: begin
        // Re-arm the timer at mid start bit so every later full tick is mid-bit
        if (w_half) begin
          w_cnt_clr = 1'b1;
          if (w_rx_s) begin
            state_d = OCIOSO;
          end else begin
            state_d   = DADOS;
            par_err_d = 1'b0;
            fr_err_d  = 1'b0;
          end
        end
      end
      DADOS: begin
        if (w_full) begin
          shift_d   = (shift_q >> 1) | (DATA_BITS'(w_rx_s) << (DATA_BITS - 1));
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == 4'(DATA_BITS - 1)) begin
            bit_idx_d = 4'd0;
            state_d   = PARIDADE;
          end
        end
      end
      PARIDADE: begin
        if (w_full) begin
          par_err_d = ^{shift_q, w_rx_s};
          state_d   = PARADA;
        end
      end
      PARADA: begin
        if (w_full) begin
          if (!w_rx_s) fr_err_d = 1'b1;
          bit_idx_d = bit_idx_q + 4'd1;
          // Character and pronto become visible during the ENTREGA cycle
          if (bit_idx_q == 4'(STOP_BITS - 1)) begin
            state_d    = ENTREGA;
            pronto_d   = 1'b1;
            dado_d     = shift_q;
            erro_par_d = par_err_q;
            erro_fr_d  = fr_err_q | ~w_rx_s;
          end
        end
      end
      ENTREGA: begin
        // A limpa seen alongside pronto consumes the old character, not the new one
        state_d    = OCIOSO;
        tem_dado_d = 1'b1;
        overrun_d  = bus.limpa ? 1'b0 : (overrun_q | tem_dado_q);
      end
      default: state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= OCIOSO;
      sync_q     <= 2'b11;
      bit_idx_q  <= 4'd0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      fr_err_q   <= 1'b0;
      dado_q     <= '0;
      erro_par_q <= 1'b0;
      erro_fr_q  <= 1'b0;
      pronto_q   <= 1'b0;
      tem_dado_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      par_err_q  <= par_err_d;
      fr_err_q   <= fr_err_d;
      dado_q     <= dado_d;
      erro_par_q <= erro_par_d;
      erro_fr_q  <= erro_fr_d;
      pronto_q   <= pronto_d;
      tem_dado_q <= tem_dado_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.dado          = dado_q;
  assign bus.pronto        = pronto_q;
  assign bus.tem_dado      = tem_dado_q;
  assign bus.erro_paridade = erro_par_q;
  assign bus.erro_frame    = erro_fr_q;
  assign bus.overrun       = overrun_q;
  assign bus.db_estado     = state_q;
endmodule
`default_nettype wire

// File: tb/tb_neurosync_serial_rx.sv
`default_nettype none
// ============================================================================
// tb_neurosync_serial_rx : directed 7E2 frames against the receiver, BIT_DIV=8
// Revision: 1.0
// ============================================================================
module tb_neurosync_serial_rx;
  localparam int BIT_DIV = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   start_cyc = 0;
  int   last_pronto_cyc = 0;
  int   pronto_cnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  neurosync_serial_rx_if #(.DATA_BITS(7)) bus ();

  neurosync_serial_rx #(.BIT_DIV(BIT_DIV), .DATA_BITS(7), .STOP_BITS(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus.pronto === 1'b1) begin
      pronto_cnt++;
      last_pronto_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; frame = start, data LSB-first, parity, stop1, stop2
  task automatic send_frame(input logic [6:0] d, input logic par_flip,
                            input logic stop1, input logic stop2);
    logic [10:0] f;
    f = {stop2, stop1, (^d) ^ par_flip, d, 1'b0};
    start_cyc = cyc;
    for (int i = 0; i < 11; i++) begin
      bus.rx = f[i];
      repeat (BIT_DIV) @(negedge clock);
    end
  endtask

  task automatic pulse_limpa();
    bus.limpa = 1'b1;
    @(negedge clock);
    bus.limpa = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    int p0;
    int lat;
    logic got;
    bus.rx    = 1'b1;
    bus.limpa = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_dado",      bus.dado, 0);
    check("reset_tem_dado",  bus.tem_dado, 0);
    check("reset_pronto",    bus.pronto, 0);
    check("reset_db_estado", bus.db_estado, 0);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    // 1: clean 0x35
    p0 = pronto_cnt;
    send_frame(7'h35, 1'b0, 1'b1, 1'b1);
    repeat (2) @(negedge clock);
    lat = last_pronto_cyc - start_cyc;
    check("t1_pronto_count", pronto_cnt - p0, 1);
    check("t1_latency_ok",   (lat >= 81 && lat <= 87) ? 1 : 0, 1);
    check("t1_dado",         bus.dado, 7'h35);
    check("t1_tem_dado",     bus.tem_dado, 1);
    check("t1_erro_par",     bus.erro_paridade, 0);
    check("t1_erro_frame",   bus.erro_frame, 0);
    pulse_limpa();
    check("t1_limpa_tem",    bus.tem_dado, 0);
    check("t1_limpa_dado",   bus.dado, 7'h35);

    // 2: 0x35 with inverted parity
    send_frame(7'h35, 1'b1, 1'b1, 1'b1);
    repeat (2) @(negedge clock);
    check("t2_dado",       bus.dado, 7'h35);
    check("t2_erro_par",   bus.erro_paridade, 1);
    check("t2_erro_frame", bus.erro_frame, 0);
    pulse_limpa();

    // 3: back-to-back 0x11, 0x22 without limpa
    p0 = pronto_cnt;
    send_frame(7'h11, 1'b0, 1'b1, 1'b1);
    send_frame(7'h22, 1'b0, 1'b1, 1'b1);
    repeat (2) @(negedge clock);
    check("t3_pronto_count", pronto_cnt - p0, 2);
    check("t3_dado",         bus.dado, 7'h22);
    check("t3_overrun",      bus.overrun, 1);
    check("t3_erro_par",     bus.erro_paridade, 0);
    pulse_limpa();
    check("t3_limpa_tem",     bus.tem_dado, 0);
    check("t3_limpa_overrun", bus.overrun, 0);

    // 4: 3-cycle glitch
    p0 = pronto_cnt;
    bus.rx = 1'b0;
    repeat (3) @(negedge clock);
    check("t4_inicio", bus.db_estado, 1);
    bus.rx = 1'b1;
    repeat (12) @(negedge clock);
    check("t4_ocioso",    bus.db_estado, 0);
    check("t4_no_pronto", pronto_cnt - p0, 0);

    // 5: first stop bit low, then limpa coincident with next delivery
    p0 = pronto_cnt;
    send_frame(7'h2A, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clock);
    check("t5_pronto_count", pronto_cnt - p0, 1);
    check("t5_dado",         bus.dado, 7'h2A);
    check("t5_erro_frame",   bus.erro_frame, 1);
    check("t5_erro_par",     bus.erro_paridade, 0);
    check("t5_tem_dado",     bus.tem_dado, 1);
    got = 1'b0;
    fork
      send_frame(7'h4C, 1'b0, 1'b1, 1'b1);
      begin
        for (int i = 0; i < 200; i++) begin
          @(negedge clock);
          if (bus.pronto === 1'b1) begin
            got = 1'b1;
            break;
          end
        end
        if (got) begin
          bus.limpa = 1'b1;
          @(negedge clock);
          bus.limpa = 1'b0;
        end
      end
    join
    repeat (2) @(negedge clock);
    check("t5_pronto_seen",   got, 1);
    check("t5_same_tem",      bus.tem_dado, 1);
    check("t5_same_overrun",  bus.overrun, 0);
    check("t5_same_dado",     bus.dado, 7'h4C);
    check("t5_same_frame_ok", bus.erro_frame, 0);

    // 6: reset during data bits of 0x7F, then clean 0x01
    p0 = pronto_cnt;
    fork
      send_frame(7'h7F, 1'b0, 1'b1, 1'b1);
      begin
        repeat (30) @(negedge clock);
        check("t6_in_dados", bus.db_estado, 2);
        reset = 1'b1;
        #1;
        check("t6_rst_dado",     bus.dado, 0);
        check("t6_rst_tem",      bus.tem_dado, 0);
        check("t6_rst_flags",    {bus.erro_paridade, bus.erro_frame, bus.overrun, bus.pronto}, 0);
        check("t6_rst_estado",   bus.db_estado, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
      end
    join
    repeat (2) @(negedge clock);
    check("t6_no_pronto", pronto_cnt - p0, 0);
    p0 = pronto_cnt;
    send_frame(7'h01, 1'b0, 1'b1, 1'b1);
    repeat (2) @(negedge clock);
    check("t6_pronto_count", pronto_cnt - p0, 1);
    check("t6_dado",         bus.dado, 7'h01);
    check("t6_tem_dado",     bus.tem_dado, 1);
    check("t6_flags",        {bus.erro_paridade, bus.erro_frame, bus.overrun}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
